dram_rdbuf: RTL and testbench
=============================

# dram_rdbuf

Read-return buffer for one DDR channel: sits directly downstream of the DDR pad channel and consumes its captured read beats (256-bit data plus 32-bit ECC per beat, qualified by the data-valid strobe). It pairs two consecutive beats into one 64-byte line and queues lines in a small FIFO. The FIFO drains to the DRAM controller over a valid/ready handshake. Overflow and framing faults are flagged as sticky errors rather than silently corrupting lines.

## Interface
- DEPTH, 4, FIFO line entries; power of two, ≥2
- rclk  in  1  channel clock (pad-header rclk)
- arst  in  1  reset; asynchronous, active-high
- io_dram_data_valid  in  1  beat qualifier from pad channel
- io_dram_data_in  in  256  beat data
- io_dram_ecc_in  in  32  beat ECC
- dram_io_channel_disabled  in  1  channel off; flushes buffer
- rdbuf_err_clr  in  1  clears sticky error flags
- rdbuf_line_rdy  in  1  controller accepts head line
- rdbuf_line_vld  out  1  head line valid
- rdbuf_line_data  out  512  {beat1, beat0} data
- rdbuf_line_ecc  out  64  {beat1, beat0} ECC
- rdbuf_ovf_err  out  1  sticky; a line was dropped because the FIFO was full
- rdbuf_frame_err  out  1  sticky; a half line was discarded
- rdbuf_cnt  out  log2(DEPTH)+1  occupied entries
- rdbuf_line_cnt, rdbuf_drop_cnt  out  16 each  present only with DRAM_RDBUF_STATS_EN

## Operation
- Pairing FSM, states EMPTY and HALF.
  - EMPTY + valid: latch the beat as beat0 and go to HALF.
  - HALF + valid: form the line {beat1, beat0}, push it, and return to EMPTY.
  - HALF + !valid: discard beat0, set frame_err, and return to EMPTY.
- Push and pop:
  - A push is accepted if cnt<DEPTH, or if cnt==DEPTH and a pop occurs in the same cycle.
  - Otherwise the line is dropped, ovf_err is set, and FIFO contents are unchanged.
  - A pop occurs when vld&&rdy.
  - If push and pop happen together, cnt is unchanged.
  - Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Output path:
  - rdbuf_line_data and rdbuf_line_ecc present the head entry directly from storage.
  - Their values are undefined unless vld=1.
  - vld = (cnt!=0).
- Channel disable:
  - While dram_io_channel_disabled=1, the FIFO is flushed (pointers=0, cnt=0) and the FSM is held in EMPTY.
  - Incoming beats are ignored and set no error.
  - vld=0 on the next cycle.
- Error flags:
  - Flags are set-dominant: if a set and rdbuf_err_clr occur in the same cycle, the flag stays 1.
- Reset:
  - Asserting arst at any time, including mid-pair or with the FIFO full, loses all contents immediately.
  - Reset values: vld=0, cnt=0, data=0, ecc=0, ovf_err=0, frame_err=0, FSM=EMPTY, counters=0.

## Timing
- Beat latency: beat1 captured at edge N makes the line visible with vld=1 after edge N (cycle N+1), provided the FIFO was empty.
- Back-to-back: the pipeline sustains one line per two cycles with continuous valid, which is full pad bandwidth.
- Pop update: after a pop at edge M, the next entry (or vld=0) is visible after edge M.
- Ready is purely combinational into pop; there is no combinational path from rdbuf_line_rdy to any output other than through registered state.
- Pad-side backpressure: there is none. The pad side cannot be stalled, which is why overflow drops instead of stalling.

## Configuration
- DRAM_RDBUF_STATS_EN defined: adds rdbuf_line_cnt and rdbuf_drop_cnt.
  - rdbuf_line_cnt increments on each accepted push.
  - rdbuf_drop_cnt increments on each overflow drop and each frame discard.
  - Both are 16-bit, saturate at 0xFFFF, reset to 0 and clear on rdbuf_err_clr.
  - If an increment and rdbuf_err_clr occur in the same cycle, the counter loads 1.
- Not defined: the counters and their ports are absent. Core behaviour is identical.

## Test plan
- Single line: beats A then B on consecutive cycles, rdy=1 -> vld=1 for one cycle with data={B,A}, cnt returns to 0, no error flags.
- Fill and overflow, DEPTH=4, rdy=0: 10 consecutive beats -> cnt=4, ovf_err=1, drop_cnt=1; popping 4 lines yields lines 1–4 in order.
- Full with simultaneous push and pop: cnt=4, rdy=1 while a 5th line completes -> cnt stays 4, ovf_err=0, line 5 appears after lines 2–4.
- Frame fault: valid high for 1 cycle, then low -> frame_err=1, cnt=0. Then rdbuf_err_clr=1 -> frame_err=0 on the next cycle.
- Channel disable: 3 lines queued, disabled=1 -> vld=0 next cycle, cnt=0. Beats during disable produce nothing.
- Reset mid-pair: assert arst after beat0 -> all outputs 0 immediately. After release, beats C,D -> line {D,C} with no frame_err.

Source files
------------

// File: rtl/dram_rdbuf.sv
// Read-return buffer: pairs DDR read beats into 64-byte lines and queues them for the controller.
// Optional line/drop statistics counters are enabled with `define DRAM_RDBUF_STATS_EN.
module dram_rdbuf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     rclk,
    input  logic                     arst,
    input  logic                     io_dram_data_valid,
    input  logic [255:0]             io_dram_data_in,
    input  logic [31:0]              io_dram_ecc_in,
    input  logic                     dram_io_channel_disabled,
    input  logic                     rdbuf_err_clr,
    input  logic                     rdbuf_line_rdy,
    output logic                     rdbuf_line_vld,
    output logic [511:0]             rdbuf_line_data,
    output logic [63:0]              rdbuf_line_ecc,
    output logic                     rdbuf_ovf_err,
    output logic                     rdbuf_frame_err,
    output logic [$clog2(DEPTH):0]   rdbuf_cnt
`ifdef DRAM_RDBUF_STATS_EN
    ,
    output logic [15:0]              rdbuf_line_cnt,
    output logic [15:0]              rdbuf_drop_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {EMPTY, HALF} state_e;

    state_e          state_q, state_d;
    logic [255:0]    beat0_data_q;
    logic [31:0]     beat0_ecc_q;
    logic            capture, push, frame_set;
    logic            pop, push_ok, ovf_set;

    logic [511:0]    mem_data_q [DEPTH];
    logic [63:0]     mem_ecc_q  [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d, frame_q, frame_d;

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (dram_io_channel_disabled) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (io_dram_data_valid) state_d = HALF;
                HALF:    state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        capture   = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        if (!dram_io_channel_disabled) begin
            case (state_q)
                EMPTY:   capture = io_dram_data_valid;
                HALF: begin
                    push      = io_dram_data_valid;
                    frame_set = !io_dram_data_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            beat0_data_q <= '0;
            beat0_ecc_q  <= '0;
        end else if (capture) begin
            beat0_data_q <= io_dram_data_in;
            beat0_ecc_q  <= io_dram_ecc_in;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop     = (cnt_q != '0) && rdbuf_line_rdy;
    assign push_ok = push && ((cnt_q < CW'(DEPTH)) || pop);
    assign ovf_set = push && !push_ok;

    always_comb begin
        wptr_d = wptr_q + AW'(push_ok);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (dram_io_channel_disabled) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ecc_q[i]  <= '0;
            end
        end else if (push_ok) begin
            mem_data_q[wptr_q] <= {io_dram_data_in, beat0_data_q};
            mem_ecc_q[wptr_q]  <= {io_dram_ecc_in, beat0_ecc_q};
        end
    end

    assign ovf_d   = ovf_set   | (ovf_q   & ~rdbuf_err_clr);
    assign frame_d = frame_set | (frame_q & ~rdbuf_err_clr);

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            frame_q <= frame_d;
        end
    end

    assign rdbuf_line_vld  = (cnt_q != '0);
    assign rdbuf_line_data = mem_data_q[rptr_q];
    assign rdbuf_line_ecc  = mem_ecc_q[rptr_q];
    assign rdbuf_ovf_err   = ovf_q;
    assign rdbuf_frame_err = frame_q;
    assign rdbuf_cnt       = cnt_q;

`ifdef DRAM_RDBUF_STATS_EN
    logic [15:0] line_cnt_q, line_cnt_d, drop_cnt_q, drop_cnt_d;
    logic        line_inc, drop_inc;

    assign line_inc = push_ok;
    assign drop_inc = ovf_set | frame_set;

    // Clear wins over history but not over a same-cycle event, which loads 1.
    always_comb begin
        line_cnt_d = line_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (rdbuf_err_clr) begin
            line_cnt_d = {15'd0, line_inc};
            drop_cnt_d = {15'd0, drop_inc};
        end else begin
            if (line_inc && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 16'd1;
            if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            line_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            line_cnt_q <= line_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rdbuf_line_cnt = line_cnt_q;
    assign rdbuf_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dram_rdbuf.sv
// Self-checking bench for dram_rdbuf: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_dram_rdbuf;
    localparam int unsigned DEPTH = 4;

    logic         rclk = 1'b0;
    logic         arst;
    logic         valid;
    logic [255:0] din;
    logic [31:0]  ein;
    logic         dis, clr, rdy;
    logic         vld;
    logic [511:0] ldata;
    logic [63:0]  lecc;
    logic         ovf, frame;
    logic [2:0]   cnt;
`ifdef DRAM_RDBUF_STATS_EN
    logic [15:0]  lcnt, dcnt;
`endif

    dram_rdbuf #(.DEPTH(DEPTH)) dut (
        .rclk                     (rclk),
        .arst                     (arst),
        .io_dram_data_valid       (valid),
        .io_dram_data_in          (din),
        .io_dram_ecc_in           (ein),
        .dram_io_channel_disabled (dis),
        .rdbuf_err_clr            (clr),
        .rdbuf_line_rdy           (rdy),
        .rdbuf_line_vld           (vld),
        .rdbuf_line_data          (ldata),
        .rdbuf_line_ecc           (lecc),
        .rdbuf_ovf_err            (ovf),
        .rdbuf_frame_err          (frame),
        .rdbuf_cnt                (cnt)
`ifdef DRAM_RDBUF_STATS_EN
        ,
        .rdbuf_line_cnt           (lcnt),
        .rdbuf_drop_cnt           (dcnt)
`endif
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] bd(input logic [31:0] k);
        return {8{k}};
    endfunction

    function automatic logic [31:0] be(input logic [31:0] k);
        return k ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [511:0] line_d(input logic [31:0] k0, input logic [31:0] k1);
        return {bd(k1), bd(k0)};
    endfunction

    task automatic set_beat(input logic v, input logic [31:0] k);
        valid = v;
        din   = bd(k);
        ein   = be(k);
    endtask

    // Reference model: queue of complete lines plus a pending half line.
    typedef struct {
        logic [511:0] d;
        logic [63:0]  e;
    } line_t;

    line_t        mq[$];
    bit           m_half;
    logic [255:0] m_b0d;
    logic [31:0]  m_b0e;
    bit           m_ovf, m_frame;
    int           m_lines, m_drops;

    task automatic model_reset();
        mq.delete();
        m_half  = 0;
        m_ovf   = 0;
        m_frame = 0;
        m_lines = 0;
        m_drops = 0;
    endtask

    task automatic model_step();
        bit pop, li, di, os, fs;
        pop = (mq.size() != 0) && rdy;
        li = 0; di = 0; os = 0; fs = 0;
        if (dis) begin
            mq.delete();
            m_half = 0;
        end else begin
            if (pop) mq.delete(0);
            if (m_half) begin
                m_half = 0;
                if (valid) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back('{d: {din, m_b0d}, e: {ein, m_b0e}});
                        li = 1;
                    end else begin
                        os = 1;
                        di = 1;
                    end
                end else begin
                    fs = 1;
                    di = 1;
                end
            end else if (valid) begin
                m_half = 1;
                m_b0d  = din;
                m_b0e  = ein;
            end
        end
        m_ovf   = os || (m_ovf && !clr);
        m_frame = fs || (m_frame && !clr);
        if (clr) begin
            m_lines = int'(li);
            m_drops = int'(di);
        end else begin
            if (li && m_lines < 65535) m_lines++;
            if (di && m_drops < 65535) m_drops++;
        end
    endtask

    task automatic compare_model();
        check("vld", 512'(vld), 512'(mq.size() != 0));
        check("cnt", 512'(cnt), 512'(mq.size()));
        if (mq.size() != 0) begin
            check("head_data", ldata, mq[0].d);
            check("head_ecc", 512'(lecc), 512'(mq[0].e));
        end
        check("ovf_err", 512'(ovf), 512'(m_ovf));
        check("frame_err", 512'(frame), 512'(m_frame));
`ifdef DRAM_RDBUF_STATS_EN
        check("line_cnt", 512'(lcnt), 512'(m_lines));
        check("drop_cnt", 512'(dcnt), 512'(m_drops));
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge rclk);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] k;
        logic        clr;
        logic        rdy;
        logic        e_vld;
        logic [2:0]  e_cnt;
        logic        e_frame;
        logic [31:0] e_h0;
        logic [31:0] e_h1;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};
        tbl[1] = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 32'd1, 32'd2};
        tbl[2] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};
        tbl[3] = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0};
        tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};
        tbl[6] = '{1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};
        tbl[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0};
        tbl[8] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 32'd0, 32'd0};
        tbl[9] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0};

        arst = 1'b1;
        set_beat(1'b0, 32'd0);
        dis = 1'b0; clr = 1'b0; rdy = 1'b0;
        model_reset();
        #1;
        check("rst_vld", 512'(vld), 512'(0));
        check("rst_cnt", 512'(cnt), 512'(0));
        check("rst_data", ldata, 512'(0));
        check("rst_ecc", 512'(lecc), 512'(0));
        check("rst_ovf", 512'(ovf), 512'(0));
        check("rst_frame", 512'(frame), 512'(0));
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        arst = 1'b0;

        // Table: single line, frame fault, sticky/set-dominant clear
        for (int i = 0; i < 10; i++) begin
            set_beat(tbl[i].v, tbl[i].k);
            clr = tbl[i].clr;
            rdy = tbl[i].rdy;
            cycle();
            check("tbl_vld", 512'(vld), 512'(tbl[i].e_vld));
            check("tbl_cnt", 512'(cnt), 512'(tbl[i].e_cnt));
            check("tbl_frame", 512'(frame), 512'(tbl[i].e_frame));
            if (tbl[i].e_vld) check("tbl_data", ldata, line_d(tbl[i].e_h0, tbl[i].e_h1));
        end
        clr = 1'b0;

        // Fill and overflow
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b1, 32'd16 + 32'(i));
            cycle();
        end
        check("fill_cnt", 512'(cnt), 512'(4));
        check("fill_ovf", 512'(ovf), 512'(1));
`ifdef DRAM_RDBUF_STATS_EN
        check("fill_drop_cnt", 512'(dcnt), 512'(1));
`endif
        set_beat(1'b0, 32'd0);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fill_order", ldata, line_d(32'd16 + 32'(2*i), 32'd17 + 32'(2*i)));
            cycle();
        end
        check("fill_empty", 512'(vld), 512'(0));
        clr = 1'b1;
        cycle();
        clr = 1'b0;

        // Full with simultaneous push and pop
        rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_beat(1'b1, 32'h40 + 32'(i));
            cycle();
        end
        set_beat(1'b1, 32'h49);
        rdy = 1'b1;
        cycle();
        check("pp_cnt", 512'(cnt), 512'(4));
        check("pp_ovf", 512'(ovf), 512'(0));
        set_beat(1'b0, 32'd0);
        for (int j = 1; j < 5; j++) begin
            check("pp_order", ldata, line_d(32'h40 + 32'(2*j), 32'h41 + 32'(2*j)));
            cycle();
        end
        check("pp_empty", 512'(vld), 512'(0));

        // Channel disable flush
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(1'b1, 32'h50 + 32'(i));
            cycle();
        end
        check("dis_pre_cnt", 512'(cnt), 512'(3));
        dis = 1'b1;
        set_beat(1'b1, 32'h60);
        cycle();
        check("dis_vld", 512'(vld), 512'(0));
        check("dis_cnt", 512'(cnt), 512'(0));
        set_beat(1'b1, 32'h61);
        cycle();
        set_beat(1'b1, 32'h62);
        cycle();
        dis = 1'b0;
        set_beat(1'b0, 32'd0);
        cycle();
        check("dis_post_cnt", 512'(cnt), 512'(0));
        check("dis_post_frame", 512'(frame), 512'(0));

        // Reset mid-pair with a queued line present
        set_beat(1'b1, 32'h6E);
        cycle();
        set_beat(1'b1, 32'h6F);
        cycle();
        set_beat(1'b1, 32'h70);
        cycle();
        set_beat(1'b0, 32'd0);
        #1;
        arst = 1'b1;
        #1;
        check("mid_rst_vld", 512'(vld), 512'(0));
        check("mid_rst_cnt", 512'(cnt), 512'(0));
        check("mid_rst_data", ldata, 512'(0));
        check("mid_rst_ecc", 512'(lecc), 512'(0));
        check("mid_rst_frame", 512'(frame), 512'(0));
        model_reset();
        @(negedge rclk);
        arst = 1'b0;
        set_beat(1'b1, 32'h71);
        cycle();
        set_beat(1'b1, 32'h72);
        cycle();
        check("mid_rst_line", ldata, line_d(32'h71, 32'h72));
        check("mid_rst_noframe", 512'(frame), 512'(0));
        set_beat(1'b0, 32'd0);
        rdy = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < 8; w++) din[w*32 +: 32] = $urandom;
            ein = $urandom;
            rdy = ($urandom_range(0, 2) == 0);
            dis = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 15) == 0);
            cycle();
        end

        set_beat(1'b0, 32'd0);
        dis = 1'b0; clr = 1'b0; rdy = 1'b1;
        repeat (DEPTH + 2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
